// File: rtl/dds_ftw_writer.sv
// Writes a 48-bit frequency tuning word into six consecutive AD9854-class DDS
// byte registers over the parallel bus, then optionally pulses UEN.
module dds_ftw_writer #(
   parameter logic [5:0]  BASE_ADDR      = 6'h04,
   parameter int unsigned WR_LOW_CYCLES  = 2,
   parameter int unsigned WR_HIGH_CYCLES = 2,
   parameter int unsigned UEN_CYCLES     = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [47:0] FTW,
   input  logic        UPD,
   output logic [5:0]  DDS_ADDR,
   output logic [7:0]  DDS_DATA,
   output logic        DDS_WRB,
   output logic        UEN,
   output logic        BUSY,
   output logic        DONE,
   output logic [2:0]  DBG_STATE
);

   // Handshake: START is accepted only while idle or finishing (BUSY=0); FTW and
   // UPD are captured on that cycle, BUSY rises on the next cycle, and DONE
   // pulses for exactly one cycle at completion. UEN is a plain timed pulse that
   // the update-cycle block consumes; nothing acknowledges it.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_WRLOW  = 3'd2,
      S_WRHIGH = 3'd3,
      S_UPDATE = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   localparam logic [15:0] LOW_LAST  = 16'(WR_LOW_CYCLES - 1);
   localparam logic [15:0] HIGH_LAST = 16'(WR_HIGH_CYCLES - 1);
   localparam logic [15:0] UEN_LAST  = 16'(UEN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [47:0] ftw_q, ftw_d;
   logic        upd_q, upd_d;
   logic [2:0]  k_q, k_d;
   logic [15:0] cnt_q, cnt_d;

   assign DBG_STATE = state_q;

   function automatic logic [7:0] ftw_byte(input logic [47:0] w, input logic [2:0] k);
      case (k)
         3'd0:    return w[47:40];
         3'd1:    return w[39:32];
         3'd2:    return w[31:24];
         3'd3:    return w[23:16];
         3'd4:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      ftw_d   = ftw_q;
      upd_d   = upd_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_FINISH: begin
            state_d = S_IDLE;
            if (START) begin
               ftw_d   = FTW;
               upd_d   = UPD;
               k_d     = 3'd0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = 16'd0;
            state_d = S_WRLOW;
         end
         S_WRLOW: begin
            if (cnt_q == LOW_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_WRHIGH;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_WRHIGH: begin
            if (cnt_q == HIGH_LAST) begin
               cnt_d = 16'd0;
               if (k_q == 3'd5) begin
                  state_d = upd_q ? S_UPDATE : S_FINISH;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = S_SETUP;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_UPDATE: begin
            if (cnt_q == UEN_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet line up
   // with the state they belong to.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         ftw_q    <= '0;
         upd_q    <= 1'b0;
         k_q      <= 3'd0;
         cnt_q    <= 16'd0;
         DDS_ADDR <= 6'd0;
         DDS_DATA <= 8'd0;
         DDS_WRB  <= 1'b1;
         UEN      <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         state_q <= state_d;
         ftw_q   <= ftw_d;
         upd_q   <= upd_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         DDS_WRB <= (state_d != S_WRLOW);
         UEN     <= (state_d == S_UPDATE);
         BUSY    <= (state_d inside {S_SETUP, S_WRLOW, S_WRHIGH, S_UPDATE});
         DONE    <= (state_d == S_FINISH);
         if (state_d == S_SETUP) begin
            DDS_ADDR <= BASE_ADDR + {3'b000, k_d};
            DDS_DATA <= ftw_byte(ftw_d, k_d);
         end
      end
   end

endmodule

// File: tb/tb_dds_ftw_writer.sv
// Bench for dds_ftw_writer: a default instance and a wrapped-address instance
// checked cycle by cycle against a timing model built from the byte schedule.
module tb_dds_ftw_writer;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] data;
      logic       wrb;
      logic       uen;
      logic       busy;
      logic       done;
   } obs_t;

   localparam obs_t RESET_OBS = '{addr: 6'd0, data: 8'd0, wrb: 1'b1, uen: 1'b0, busy: 1'b0, done: 1'b0};

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [47:0] FTW = '0;
   logic        UPD = 1'b0;

   logic [5:0] a_addr, b_addr;
   logic [7:0] a_data, b_data;
   logic       a_wrb, a_uen, a_busy, a_done, b_wrb, b_uen, b_busy, b_done;
   logic [2:0] a_state, b_state;
   obs_t       obs_a, obs_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   dds_ftw_writer u_dut_a (
      .CLK(CLK), .RST(RST), .START(START), .FTW(FTW), .UPD(UPD),
      .DDS_ADDR(a_addr), .DDS_DATA(a_data), .DDS_WRB(a_wrb), .UEN(a_uen),
      .BUSY(a_busy), .DONE(a_done), .DBG_STATE(a_state)
   );

   dds_ftw_writer #(
      .BASE_ADDR(6'h3E), .WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(1), .UEN_CYCLES(4)
   ) u_dut_b (
      .CLK(CLK), .RST(RST), .START(START), .FTW(FTW), .UPD(UPD),
      .DDS_ADDR(b_addr), .DDS_DATA(b_data), .DDS_WRB(b_wrb), .UEN(b_uen),
      .BUSY(b_busy), .DONE(b_done), .DBG_STATE(b_state)
   );

   assign obs_a = {a_addr, a_data, a_wrb, a_uen, a_busy, a_done};
   assign obs_b = {b_addr, b_data, b_wrb, b_uen, b_busy, b_done};

   // Expected outputs in cycle c after START was sampled in cycle 0.
   function automatic obs_t model(int c, logic [5:0] base, int l, int h, int u,
                                  logic [47:0] f, bit upd);
      obs_t e;
      int   p, tw, tdone, k, off;
      p     = 1 + l + h;
      tw    = 6 * p;
      tdone = tw + 1 + (upd ? u : 0);
      k     = (c <= tw) ? (c - 1) / p : 5;
      e.addr = base + 6'(k);
      e.data = 8'(f >> (8 * (5 - k)));
      e.wrb  = 1'b1;
      e.uen  = 1'b0;
      e.busy = 1'b0;
      if (c <= tw) begin
         off    = (c - 1) % p;
         e.wrb  = !(off >= 1 && off <= l);
         e.busy = 1'b1;
      end else if (c < tdone) begin
         e.uen  = 1'b1;
         e.busy = 1'b1;
      end
      e.done = (c == tdone);
      return e;
   endfunction

   function automatic logic [47:0] rand48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      tick();
      RST   = 1'b1;
      START = 1'b0;
      repeat (2) tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      RST = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (obs_a !== RESET_OBS) begin
         n_err++;
         $display("FAIL reset_a got=%h exp=%h", obs_a, RESET_OBS);
      end
      n_cmp++;
      if (obs_b !== RESET_OBS) begin
         n_err++;
         $display("FAIL reset_b got=%h exp=%h", obs_b, RESET_OBS);
      end
      RST = 1'b0;
   endtask

   task automatic test_transfer(input string name, input logic [47:0] f, input bit upd);
      obs_t e;
      do_reset();
      tick();
      START = 1'b1;
      FTW   = f;
      UPD   = upd;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (c == 1) begin
            START = 1'b0;
            FTW   = ~f;
            UPD   = !upd;
         end
         e = model(c, 6'h04, 2, 2, 1, f, upd);
         n_cmp++;
         if (obs_a !== e) begin
            n_err++;
            $display("FAIL %s c=%0d got addr=%h data=%h wrb=%b uen=%b busy=%b done=%b exp addr=%h data=%h wrb=%b uen=%b busy=%b done=%b",
                     name, c, obs_a.addr, obs_a.data, obs_a.wrb, obs_a.uen, obs_a.busy, obs_a.done,
                     e.addr, e.data, e.wrb, e.uen, e.busy, e.done);
         end
      end
   endtask

   task automatic test_start_during_busy();
      obs_t        e;
      int          ndone;
      logic [47:0] f1, f2;
      f1 = 48'h0123_4567_89AB;
      f2 = rand48();
      ndone = 0;
      do_reset();
      tick();
      START = 1'b1;
      FTW   = f1;
      UPD   = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         tick();
         if (c == 1) START = 1'b0;
         if (c == 10) begin
            START = 1'b1;
            FTW   = 48'hFFFF_FFFF_FFFF;
            UPD   = 1'b0;
         end
         if (c == 11) START = 1'b0;
         e = model(c, 6'h04, 2, 2, 1, f1, 1'b1);
         n_cmp++;
         if (obs_a !== e) begin
            n_err++;
            $display("FAIL busy_ignore c=%0d got=%h exp=%h", c, obs_a, e);
         end
         if (obs_a.done) ndone++;
         if (c == 32) begin
            START = 1'b1;
            FTW   = f2;
            UPD   = 1'b1;
         end
      end
      n_cmp++;
      if (ndone !== 1) begin
         n_err++;
         $display("FAIL busy_done_count got=%0d exp=1", ndone);
      end
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (c == 1) START = 1'b0;
         e = model(c, 6'h04, 2, 2, 1, f2, 1'b1);
         n_cmp++;
         if (obs_a !== e) begin
            n_err++;
            $display("FAIL start_in_done c=%0d got=%h exp=%h", c, obs_a, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t        e;
      logic [47:0] f;
      f = rand48();
      do_reset();
      tick();
      START = 1'b1;
      FTW   = f;
      UPD   = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) START = 1'b0;
         e = model(c, 6'h04, 2, 2, 1, f, 1'b1);
         n_cmp++;
         if (obs_a !== e) begin
            n_err++;
            $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, obs_a, e);
         end
         if (c == 12) RST = 1'b1;
      end
      for (int c = 13; c <= 45; c++) begin
         tick();
         if (c == 13) RST = 1'b0;
         n_cmp++;
         if (obs_a !== RESET_OBS) begin
            n_err++;
            $display("FAIL reset_mid_after c=%0d got=%h exp=%h", c, obs_a, RESET_OBS);
         end
      end
      test_transfer("reset_mid_rerun", rand48(), 1'b1);
   endtask

   task automatic test_param_wrap(input bit upd);
      obs_t        e;
      logic [47:0] f;
      f = rand48();
      do_reset();
      tick();
      START = 1'b1;
      FTW   = f;
      UPD   = upd;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 1) begin
            START = 1'b0;
            FTW   = ~f;
            UPD   = !upd;
         end
         e = model(c, 6'h3E, 3, 1, 4, f, upd);
         n_cmp++;
         if (obs_b !== e) begin
            n_err++;
            $display("FAIL param_wrap upd=%0d c=%0d got addr=%h data=%h wrb=%b uen=%b busy=%b done=%b exp addr=%h data=%h wrb=%b uen=%b busy=%b done=%b",
                     upd, c, obs_b.addr, obs_b.data, obs_b.wrb, obs_b.uen, obs_b.busy, obs_b.done,
                     e.addr, e.data, e.wrb, e.uen, e.busy, e.done);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         test_transfer("random", rand48(), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_transfer("basic", 48'h0123_4567_89AB, 1'b1);
      test_transfer("skip_update", 48'h0123_4567_89AB, 1'b0);
      test_start_during_busy();
      test_reset_mid();
      test_param_wrap(1'b1);
      test_param_wrap(1'b0);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
